cu_mc: RTL and testbench

//  Parametrised multicycle control unit for mycpu. Generalises the single-step decoder:
//  - configurable register-address width;
//  - a ready/timeout handshake for I/O instructions;
//  - a stepped EXN sequencer for multi-cycle macro-ops.

---
 rtl/mycpu_pkg.sv | 38 +++
 rtl/cu_io_timer.sv | 44 ++++
 rtl/cu_mc.sv | 186 ++++++++++++++++++
 tb/tb_cu_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared mycpu definitions: opcode encoding, ALU function codes and the
// multicycle control-unit state type, PC-op and writeback-mux codes.
package mycpu_pkg;

  typedef enum logic [6:0] {
    MOVA = 7'h00, INC  = 7'h01, ADD  = 7'h02, SUB  = 7'h05,
    DEC  = 7'h06, AND  = 7'h08, OR   = 7'h09, XOR  = 7'h0A,
    NOT  = 7'h0B, MOVB = 7'h0C, SHR  = 7'h0D, SHL  = 7'h0E,
    CLR  = 7'h0F, LD   = 7'h10, ST   = 7'h20, IOR  = 7'h30,
    IOW  = 7'h31, XXL  = 7'h38, ADI  = 7'h42, LDI  = 7'h4C,
    BRZ  = 7'h60, BRN  = 7'h61, JMP  = 7'h70, HAL  = 7'h7F
  } opcode_t;

  localparam logic [3:0] FADD    = 4'h2;
  localparam logic [3:0] FSRA    = 4'h7;
  localparam logic [3:0] FS_IDLE = 4'hF;

  typedef enum logic [2:0] {RST, INF, EX0, EXN, IOWT, HLT} cu_mc_state_t;

  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_BR   = 2'b10;
  localparam logic [1:0] PS_JMP  = 2'b11;

  localparam logic [1:0] MD_ALU = 2'b00;
  localparam logic [1:0] MD_MEM = 2'b01;
  localparam logic [1:0] MD_IO  = 2'b10;

  // Register-to-register ops whose ALU function is the opcode's low nibble.
  function automatic logic is_alu_op(input opcode_t op);
    case (op)
      MOVA, INC, ADD, SUB, DEC, AND, OR, XOR, NOT,
      MOVB, SHR, SHL, CLR, LDI, ADI: is_alu_op = 1'b1;
      default:                       is_alu_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_io_timer.sv
// I/O wait counter for the control unit: counts IOWT cycles, flags the
// timeout on the last allowed cycle without ready, and keeps a sticky error.
module cu_io_timer #(
  parameter int IO_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic rdy,
  output logic tmo,
  output logic err
);

  localparam int CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(IO_TIMEOUT - 1);

  logic [CW-1:0] io_cnt_r;
  logic          io_err_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_cnt_r <= '0;
    end else if (clr) begin
      io_cnt_r <= '0;
    end else if (en) begin
      io_cnt_r <= io_cnt_r + 1'b1;
    end
  end

  // Ready on the final cycle still completes the transfer.
  assign tmo = en && !rdy && (io_cnt_r == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_err_r <= 1'b0;
    end else if (tmo) begin
      io_err_r <= 1'b1;
    end
  end

  assign err = io_err_r;

endmodule

// File: rtl/cu_mc.sv
// Multicycle control unit for mycpu with I/O ready/timeout handshake.
// Optional MYCPU_AVG_EN: XXL (D <- (A+B)>>>1) executed as a two-step macro-op.
module cu_mc
  import mycpu_pkg::*;
#(
  parameter int IW         = 16,
  parameter int OPW        = 7,
  parameter int RA_W       = 3,
  parameter int IO_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IW-1:0]           ins_in,
  input  logic                    z_in,
  input  logic                    n_in,
  input  logic                    io_rdy_in,
  output logic                    il_out,
  output logic [1:0]              ps_out,
  output logic                    rw_out,
  output logic [3*(RA_W+1)-1:0]   rs_out,
  output logic                    mm_out,
  output logic [1:0]              md_out,
  output logic                    mb_out,
  output logic [3:0]              fs_out,
  output logic                    wen_out,
  output logic                    iom_out,
  output logic                    io_req_out,
  output logic                    halted_out,
  output logic                    io_err_out
);

  cu_mc_state_t st_r, w_st_nx;

  logic [OPW-1:0]  w_opc;
  opcode_t         w_op;
  logic [RA_W-1:0] w_fd, w_fa, w_fb, w_rs_a;
  logic            w_tmr_clr, w_tmr_en, w_tmo, w_err;

  assign w_opc = ins_in[IW-1 -: OPW];
  assign w_op  = opcode_t'(w_opc);
  assign w_fd  = ins_in[3*RA_W-1 -: RA_W];
  assign w_fa  = ins_in[2*RA_W-1 -: RA_W];
  assign w_fb  = ins_in[RA_W-1:0];

`ifdef MYCPU_AVG_EN
  logic step_r, w_step_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_r <= 1'b0;
    end else begin
      step_r <= w_step_nx;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_r <= RST;
    end else begin
      st_r <= w_st_nx;
    end
  end

  always_comb begin
    w_st_nx    = st_r;
    il_out     = 1'b0;
    ps_out     = PS_HOLD;
    rw_out     = 1'b0;
    mm_out     = 1'b0;
    md_out     = MD_ALU;
    mb_out     = 1'b0;
    fs_out     = FS_IDLE;
    wen_out    = 1'b1;
    iom_out    = 1'b0;
    io_req_out = 1'b0;
    w_rs_a     = w_fa;
    w_tmr_clr  = 1'b0;
    w_tmr_en   = 1'b0;
`ifdef MYCPU_AVG_EN
    w_step_nx  = step_r;
`endif
    case (st_r)
      RST: w_st_nx = INF;
      INF: begin
        il_out  = 1'b1;
        mm_out  = 1'b1;
        w_st_nx = EX0;
      end
      EX0: begin
        w_st_nx = INF;
        if (is_alu_op(w_op)) begin
          ps_out = PS_INC;
          rw_out = 1'b1;
          fs_out = w_opc[3:0];
          mb_out = (w_op == LDI) || (w_op == ADI);
        end else begin
          case (w_op)
            LD: begin
              ps_out = PS_INC;
              rw_out = 1'b1;
              md_out = MD_MEM;
            end
            ST: begin
              ps_out  = PS_INC;
              wen_out = 1'b0;
            end
            BRZ: begin
              ps_out = z_in ? PS_BR : PS_INC;
              fs_out = 4'h0;
            end
            BRN: begin
              ps_out = n_in ? PS_BR : PS_INC;
              fs_out = 4'h0;
            end
            JMP: ps_out = PS_JMP;
            IOR, IOW: begin
              w_tmr_clr = 1'b1;
              w_st_nx   = IOWT;
            end
`ifdef MYCPU_AVG_EN
            XXL: begin
              if (!step_r) begin
                rw_out    = 1'b1;
                fs_out    = FADD;
                w_step_nx = 1'b1;
                w_st_nx   = EXN;
              end
            end
`endif
            default: w_st_nx = HLT;
          endcase
        end
      end
      EXN: begin
`ifdef MYCPU_AVG_EN
        // Second step shifts the sum already written back into D.
        w_rs_a    = w_fd;
        rw_out    = 1'b1;
        fs_out    = FSRA;
        ps_out    = PS_INC;
        w_step_nx = 1'b0;
        w_st_nx   = INF;
`else
        w_st_nx   = HLT;
`endif
      end
      IOWT: begin
        w_tmr_en   = 1'b1;
        io_req_out = 1'b1;
        iom_out    = 1'b1;
        if (io_rdy_in) begin
          ps_out  = PS_INC;
          w_st_nx = INF;
          if (w_op == IOR) begin
            rw_out = 1'b1;
            md_out = MD_IO;
          end else begin
            wen_out = 1'b0;
          end
        end else if (w_tmo) begin
          w_st_nx = HLT;
        end
      end
      HLT: w_st_nx = HLT;
      default: w_st_nx = RST;
    endcase
  end

  assign rs_out     = {1'b0, w_fd, 1'b0, w_rs_a, 1'b0, w_fb};
  assign halted_out = (st_r == HLT);
  assign io_err_out = w_err;

  cu_io_timer #(
    .IO_TIMEOUT(IO_TIMEOUT)
  ) u_io_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (w_tmr_clr),
    .en   (w_tmr_en),
    .rdy  (io_rdy_in),
    .tmo  (w_tmo),
    .err  (w_err)
  );

endmodule

// File: tb/tb_cu_mc.sv
// Directed bench for cu_mc: expected output sets queued per cycle and checked
// mid-cycle; a tiny register-file model follows the DUT's write controls.
module tb_cu_mc;
  import mycpu_pkg::*;

  typedef struct packed {
    logic        il;
    logic [1:0]  ps;
    logic        rw;
    logic [11:0] rs;
    logic        mm;
    logic [1:0]  md;
    logic        mb;
    logic [3:0]  fs;
    logic        wen;
    logic        iom;
    logic        io_req;
    logic        halted;
    logic        io_err;
  } ov_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins;
  logic        z, n, rdy;
  logic        il, rw, mm, mb, wen, iom, io_req, halted, io_err;
  logic [1:0]  ps, md;
  logic [11:0] rs;
  logic [3:0]  fs;

  ov_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  logic [7:0] rf [8];
  logic       preload = 1'b0;

  always #5 clk = ~clk;

  cu_mc dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins), .z_in(z), .n_in(n),
    .io_rdy_in(rdy), .il_out(il), .ps_out(ps), .rw_out(rw), .rs_out(rs),
    .mm_out(mm), .md_out(md), .mb_out(mb), .fs_out(fs), .wen_out(wen),
    .iom_out(iom), .io_req_out(io_req), .halted_out(halted),
    .io_err_out(io_err)
  );

  // Datapath model: only the add and arithmetic-shift functions matter here.
  always @(posedge clk) begin
    if (preload) begin
      rf[1] <= 8'd5;
      rf[2] <= 8'd8;
    end else if (rw && md == 2'b00) begin
      if (fs == 4'h2) rf[rs[10:8]] <= rf[rs[6:4]] + rf[rs[2:0]];
      else if (fs == 4'h7) rf[rs[10:8]] <= 8'($signed(rf[rs[6:4]]) >>> 1);
    end
  end

  function automatic logic [15:0] mk(input opcode_t op, input logic [2:0] d, a, b);
    return {op, d, a, b};
  endfunction

  function automatic ov_t idl(input logic [15:0] i);
    ov_t e;
    e     = '0;
    e.rs  = {1'b0, i[8:6], 1'b0, i[5:3], 1'b0, i[2:0]};
    e.fs  = 4'hF;
    e.wen = 1'b1;
    return e;
  endfunction

  function automatic ov_t infx(input logic [15:0] i);
    ov_t e;
    e    = idl(i);
    e.il = 1'b1;
    e.mm = 1'b1;
    return e;
  endfunction

  function automatic ov_t wt(input logic [15:0] i);
    ov_t e;
    e        = idl(i);
    e.io_req = 1'b1;
    e.iom    = 1'b1;
    return e;
  endfunction

  function automatic ov_t hlt(input logic [15:0] i, input logic err);
    ov_t e;
    e        = idl(i);
    e.halted = 1'b1;
    e.io_err = err;
    return e;
  endfunction

  task automatic sample(input string tag);
    ov_t e, g;
    n_tests++;
    if (q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q.pop_front();
    g = ov_t'({il, ps, rw, rs, mm, md, mb, fs, wen, iom, io_req, halted, io_err});
    assert (g === e) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, g, e);
    end
  endtask

  task automatic cyc(input string tag, input ov_t e);
    q.push_back(e);
    @(negedge clk);
    sample(tag);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset: outputs must go idle without waiting for a clock.
  task automatic reset_pulse(input string tag);
    q.push_back(idl(ins));
    rst_n = 1'b0;
    #2;
    sample(tag);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc({tag, "_rst"}, idl(ins));
  endtask

  initial begin
    ov_t e;
    rst_n = 1'b0;
    ins   = '0;
    z     = 1'b0;
    n     = 1'b0;
    rdy   = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", idl(ins));
    rst_n = 1'b1;
    cyc("rst_release", idl(ins));

    ins = mk(ADD, 3'd1, 3'd2, 3'd3);
    cyc("add_inf", infx(ins));
    e = idl(ins); e.ps = 2'b01; e.rw = 1'b1; e.fs = 4'h2; e.rs = 12'h123;
    cyc("add_ex0", e);

    ins = mk(LDI, 3'd4, 3'd0, 3'd5);
    cyc("ldi_inf", infx(ins));
    e = idl(ins); e.ps = 2'b01; e.rw = 1'b1; e.fs = 4'hC; e.mb = 1'b1;
    cyc("ldi_ex0", e);

    ins = mk(LD, 3'd2, 3'd6, 3'd0);
    cyc("ld_inf", infx(ins));
    e = idl(ins); e.ps = 2'b01; e.rw = 1'b1; e.md = 2'b01;
    cyc("ld_ex0", e);

    ins = mk(ST, 3'd0, 3'd1, 3'd7);
    cyc("st_inf", infx(ins));
    e = idl(ins); e.ps = 2'b01; e.wen = 1'b0;
    cyc("st_ex0", e);

    ins = mk(JMP, 3'd0, 3'd3, 3'd0);
    cyc("jmp_inf", infx(ins));
    e = idl(ins); e.ps = 2'b11;
    cyc("jmp_ex0", e);

    ins = mk(BRZ, 3'd0, 3'd1, 3'd2);
    z = 1'b1;
    cyc("brz1_inf", infx(ins));
    e = idl(ins); e.ps = 2'b10; e.fs = 4'h0;
    cyc("brz1_ex0", e);
    z = 1'b0;
    cyc("brz0_inf", infx(ins));
    e = idl(ins); e.ps = 2'b01; e.fs = 4'h0;
    cyc("brz0_ex0", e);

    ins = mk(BRN, 3'd0, 3'd5, 3'd1);
    n = 1'b1;
    z = 1'b1;
    cyc("brn1_inf", infx(ins));
    e = idl(ins); e.ps = 2'b10; e.fs = 4'h0;
    cyc("brn1_ex0", e);
    n = 1'b0;
    cyc("brn0_inf", infx(ins));
    e = idl(ins); e.ps = 2'b01; e.fs = 4'h0;
    cyc("brn0_ex0", e);
    z = 1'b0;

    ins = mk(IOR, 3'd3, 3'd0, 3'd0);
    cyc("ior_inf", infx(ins));
    cyc("ior_ex0", idl(ins));
    cyc("ior_w1", wt(ins));
    cyc("ior_w2", wt(ins));
    rdy = 1'b1;
    e = wt(ins); e.rw = 1'b1; e.md = 2'b10; e.ps = 2'b01;
    cyc("ior_w3", e);
    rdy = 1'b0;
    ins = mk(MOVA, 3'd1, 3'd1, 3'd0);
    cyc("ior_next_inf", infx(ins));
    e = idl(ins); e.ps = 2'b01; e.rw = 1'b1; e.fs = 4'h0;
    cyc("mova_ex0", e);

    ins = mk(IOR, 3'd2, 3'd0, 3'd0);
    cyc("ior2_inf", infx(ins));
    cyc("ior2_ex0", idl(ins));
    cyc("ior2_w1", wt(ins));
    reset_pulse("rst_iowt");
    cyc("rst_iowt_inf", infx(ins));
    cyc("ior2b_ex0", idl(ins));
    rdy = 1'b1;
    e = wt(ins); e.rw = 1'b1; e.md = 2'b10; e.ps = 2'b01;
    cyc("ior2b_w1", e);
    rdy = 1'b0;

    ins = mk(XXL, 3'd0, 3'd1, 3'd2);
`ifdef MYCPU_AVG_EN
    preload = 1'b1;
    cyc("xxl_inf", infx(ins));
    preload = 1'b0;
    e = idl(ins); e.rw = 1'b1; e.fs = 4'h2; e.ps = 2'b00;
    cyc("xxl_ex0", e);
    e = idl(ins); e.rw = 1'b1; e.fs = 4'h7; e.ps = 2'b01; e.rs = 12'h002;
    cyc("xxl_exn", e);
    n_tests++;
    assert (rf[0] === 8'd6) else begin
      n_fail++;
      $error("FAIL xxl_r0: observed=%0d expected=6", rf[0]);
    end
    cyc("xxl2_inf", infx(ins));
    e = idl(ins); e.rw = 1'b1; e.fs = 4'h2;
    cyc("xxl2_ex0", e);
    reset_pulse("rst_exn");
`else
    cyc("xxl_inf", infx(ins));
    cyc("xxl_ex0", idl(ins));
    cyc("xxl_hlt", hlt(ins, 1'b0));
    reset_pulse("rst_xxl");
`endif

    ins = mk(IOW, 3'd0, 3'd4, 3'd5);
    cyc("iow_inf", infx(ins));
    cyc("iow_ex0", idl(ins));
    for (int i = 0; i < 15; i++) cyc($sformatf("iow_w%0d", i + 1), wt(ins));
    for (int i = 0; i < 21; i++) cyc($sformatf("tmo_hlt%0d", i), hlt(ins, 1'b1));
    reset_pulse("rst_hlt");

    ins = mk(HAL, 3'd0, 3'd0, 3'd0);
    cyc("hal_inf", infx(ins));
    cyc("hal_ex0", idl(ins));
    cyc("hal_hlt", hlt(ins, 1'b0));
    reset_pulse("rst_hal");

    ins = {7'h7E, 9'h0AB};
    cyc("ill_inf", infx(ins));
    cyc("ill_ex0", idl(ins));
    cyc("ill_hlt", hlt(ins, 1'b0));

    n_tests++;
    assert (q.size() === 0) else begin
      n_fail++;
      $error("FAIL queue_drain: observed=%0d expected=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
